// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/response and chain signals of the two-master core-bus arbiter
// Ports (signal groups):
//   m0_*/m1_*  : per-master request slot (addr, wdata, rw, valid, ready) and response (rdata, rvalid, timeout)
//   *_o chain  : chain head request (addr_o, wdata_o, rw_o, valid_o)
//   ret_*      : chain tail return beat (addr, wdata, rdata, rw, valid)
// Modports: slave = arbiter side, master = requester/chain side.
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] m0_addr_i;
    logic [DATA_WIDTH-1:0] m0_wdata_i;
    logic                  m0_rw_i;
    logic                  m0_valid_i;
    logic                  m0_ready_o;
    logic [DATA_WIDTH-1:0] m0_rdata_o;
    logic                  m0_rvalid_o;
    logic                  m0_timeout_o;

    logic [ADDR_WIDTH-1:0] m1_addr_i;
    logic [DATA_WIDTH-1:0] m1_wdata_i;
    logic                  m1_rw_i;
    logic                  m1_valid_i;
    logic                  m1_ready_o;
    logic [DATA_WIDTH-1:0] m1_rdata_o;
    logic                  m1_rvalid_o;
    logic                  m1_timeout_o;

    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic                  rw_o;
    logic                  valid_o;

    logic [ADDR_WIDTH-1:0] ret_addr_i;
    logic [DATA_WIDTH-1:0] ret_wdata_i;
    logic [DATA_WIDTH-1:0] ret_rdata_i;
    logic                  ret_rw_i;
    logic                  ret_valid_i;

    modport slave (
        input  m0_addr_i, m0_wdata_i, m0_rw_i, m0_valid_i,
        output m0_ready_o, m0_rdata_o, m0_rvalid_o, m0_timeout_o,
        input  m1_addr_i, m1_wdata_i, m1_rw_i, m1_valid_i,
        output m1_ready_o, m1_rdata_o, m1_rvalid_o, m1_timeout_o,
        output addr_o, wdata_o, rw_o, valid_o,
        input  ret_addr_i, ret_wdata_i, ret_rdata_i, ret_rw_i, ret_valid_i
    );

    modport master (
        output m0_addr_i, m0_wdata_i, m0_rw_i, m0_valid_i,
        input  m0_ready_o, m0_rdata_o, m0_rvalid_o, m0_timeout_o,
        output m1_addr_i, m1_wdata_i, m1_rw_i, m1_valid_i,
        input  m1_ready_o, m1_rdata_o, m1_rvalid_o, m1_timeout_o,
        input  addr_o, wdata_o, rw_o, valid_o,
        output ret_addr_i, ret_wdata_i, ret_rdata_i, ret_rw_i, ret_valid_i
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter sharing one core-bus chain
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bus_arbiter_if.slave - master slots/responses, chain head request, chain tail beat
module bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_arbiter_if.slave    bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                          state_q, state_d;
    logic [1:0]                      full_q, full_d;
    logic [1:0][ADDR_WIDTH-1:0]      slot_addr_q, slot_addr_d;
    logic [1:0][DATA_WIDTH-1:0]      slot_wdata_q, slot_wdata_d;
    logic [1:0]                      slot_rw_q, slot_rw_d;
    logic                            last_q, last_d;
    logic                            grant_q, grant_d;
    logic [TW-1:0]                   timer_q, timer_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
    logic                            rw_q, rw_d;
    logic                            valid_q, valid_d;
    logic [1:0][DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic [1:0]                      rvalid_q, rvalid_d;
    logic [1:0]                      tmo_q, tmo_d;

    logic [1:0][ADDR_WIDTH-1:0]      req_addr;
    logic [1:0][DATA_WIDTH-1:0]      req_wdata;
    logic [1:0]                      req_rw;
    logic [1:0]                      req_valid;
    logic                            sel;
    logic                            accept;

    assign req_addr  = {bus.m1_addr_i,  bus.m0_addr_i};
    assign req_wdata = {bus.m1_wdata_i, bus.m0_wdata_i};
    assign req_rw    = {bus.m1_rw_i,    bus.m0_rw_i};
    assign req_valid = {bus.m1_valid_i, bus.m0_valid_i};

    // The issued address/rw are held on the chain head for the whole WAIT,
    // so the head registers double as the match key for return beats.
    assign accept = (state_q == S_WAIT) && bus.ret_valid_i &&
                    (bus.ret_addr_i == addr_q) && (bus.ret_rw_i == rw_q);

    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        slot_rw_d    = slot_rw_q;
        last_d       = last_q;
        grant_d      = grant_q;
        timer_d      = timer_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        valid_d      = 1'b0;
        rdata_d      = rdata_q;
        rvalid_d     = 2'b00;
        tmo_d        = 2'b00;
        sel          = 1'b0;

        // Slot capture only touches empty slots, so it can never collide
        // with the clear of the granted (full) slot below.
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && !full_q[i]) begin
                full_d[i]       = 1'b1;
                slot_addr_d[i]  = req_addr[i];
                slot_wdata_d[i] = req_wdata[i];
                slot_rw_d[i]    = req_rw[i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|full_q) begin
                    // Tie goes to the master that was not served last.
                    sel     = (&full_q) ? ~last_q : full_q[1];
                    grant_d = sel;
                    addr_d  = slot_addr_q[sel];
                    wdata_d = slot_wdata_q[sel];
                    rw_d    = slot_rw_q[sel];
                    valid_d = 1'b1;
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = (timer_q == TMAX) ? timer_q : timer_q + 1'b1;
                // A matching beat takes priority over an expiring timer.
                if (accept) begin
                    rdata_d[grant_q]  = bus.ret_rdata_i;
                    rvalid_d[grant_q] = 1'b1;
                    full_d[grant_q]   = 1'b0;
                    last_d            = grant_q;
                    state_d           = S_IDLE;
                end else if (timer_q == TMAX) begin
                    rdata_d[grant_q]  = '0;
                    rvalid_d[grant_q] = 1'b1;
                    tmo_d[grant_q]    = 1'b1;
                    full_d[grant_q]   = 1'b0;
                    last_d            = grant_q;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            full_q       <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            slot_rw_q    <= '0;
            last_q       <= 1'b1;
            grant_q      <= 1'b0;
            timer_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            valid_q      <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            slot_rw_q    <= slot_rw_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            timer_q      <= timer_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            valid_q      <= valid_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            tmo_q        <= tmo_d;
        end
    end

    assign bus.m0_ready_o   = ~full_q[0];
    assign bus.m1_ready_o   = ~full_q[1];
    assign bus.m0_rdata_o   = rdata_q[0];
    assign bus.m1_rdata_o   = rdata_q[1];
    assign bus.m0_rvalid_o  = rvalid_q[0];
    assign bus.m1_rvalid_o  = rvalid_q[1];
    assign bus.m0_timeout_o = tmo_q[0];
    assign bus.m1_timeout_o = tmo_q[1];
    assign bus.addr_o       = addr_q;
    assign bus.wdata_o      = wdata_q;
    assign bus.rw_o         = rw_q;
    assign bus.valid_o      = valid_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) b8 ();
    bus_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) b4 ();

    bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8.slave)
    );

    bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid8(input string tag);
        int n = 0;
        while (b8.valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(b8.valid_o), 1);
    endtask

    task automatic beat8(input logic [15:0] a, input logic rw, input logic [15:0] d);
        b8.ret_addr_i  = a;
        b8.ret_rw_i    = rw;
        b8.ret_rdata_i = d;
        b8.ret_wdata_i = d;
        b8.ret_valid_i = 1'b1;
        tick();
        b8.ret_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b8.m0_addr_i = '0; b8.m0_wdata_i = '0; b8.m0_rw_i = 0; b8.m0_valid_i = 0;
        b8.m1_addr_i = '0; b8.m1_wdata_i = '0; b8.m1_rw_i = 0; b8.m1_valid_i = 0;
        b8.ret_addr_i = '0; b8.ret_wdata_i = '0; b8.ret_rdata_i = '0; b8.ret_rw_i = 0; b8.ret_valid_i = 0;
        b4.m0_addr_i = '0; b4.m0_wdata_i = '0; b4.m0_rw_i = 0; b4.m0_valid_i = 0;
        b4.m1_addr_i = '0; b4.m1_wdata_i = '0; b4.m1_rw_i = 0; b4.m1_valid_i = 0;
        b4.ret_addr_i = '0; b4.ret_wdata_i = '0; b4.ret_rdata_i = '0; b4.ret_rw_i = 0; b4.ret_valid_i = 0;

        // Reset state
        tick();
        check("rst_m0_ready", 32'(b8.m0_ready_o), 1);
        check("rst_m1_ready", 32'(b8.m1_ready_o), 1);
        check("rst_valid_o", 32'(b8.valid_o), 0);
        check("rst_addr_o", 32'(b8.addr_o), 0);
        check("rst_rvalid", 32'({b8.m0_rvalid_o, b8.m1_rvalid_o, b8.m0_timeout_o, b8.m1_timeout_o}), 0);
        check("rst_rdata", 32'({b8.m0_rdata_o, b8.m1_rdata_o}), 0);
        rst_n = 1'b1;
        tick();

        // Contention: 4 rounds, m0 write 0x0003<-0x1234, m1 read 0x0001; expect m0 then m1 each round
        for (int r = 0; r < 4; r++) begin
            b8.m0_addr_i = 16'h0003; b8.m0_wdata_i = 16'h1234; b8.m0_rw_i = 1'b1; b8.m0_valid_i = 1'b1;
            b8.m1_addr_i = 16'h0001; b8.m1_wdata_i = 16'h0000; b8.m1_rw_i = 1'b0; b8.m1_valid_i = 1'b1;
            tick();
            b8.m0_valid_i = 1'b0;
            b8.m1_valid_i = 1'b0;
            for (int k = 0; k < 2; k++) begin
                wait_valid8("cont_valid");
                check("cont_grant_addr", 32'(b8.addr_o), (k == 0) ? 'h0003 : 'h0001);
                check("cont_grant_rw", 32'(b8.rw_o), (k == 0) ? 1 : 0);
                if (k == 0) check("cont_wdata", 32'(b8.wdata_o), 'h1234);
                tick();
                check("cont_valid_one_cycle", 32'(b8.valid_o), 0);
                beat8(b8.addr_o, b8.rw_o, (k == 0) ? 16'h1234 : 16'(16'h0100 + r));
                check("cont_no_valid_at_resp", 32'(b8.valid_o), 0);
                if (k == 0) begin
                    check("cont_m0_rvalid", 32'({b8.m0_rvalid_o, b8.m1_rvalid_o}), 'b10);
                    check("cont_m0_rdata", 32'(b8.m0_rdata_o), 'h1234);
                end else begin
                    check("cont_m1_rvalid", 32'({b8.m0_rvalid_o, b8.m1_rvalid_o}), 'b01);
                    check("cont_m1_rdata", 32'(b8.m1_rdata_o), 'h0100 + r);
                end
            end
            tick();
        end

        // Single read: m0 reads 0x0000, tail returns 0x00A5 three cycles after valid_o
        b8.m0_addr_i = 16'h0000; b8.m0_rw_i = 1'b0; b8.m0_valid_i = 1'b1;
        tick();
        b8.m0_valid_i = 1'b0;
        check("sr_m0_ready_low", 32'(b8.m0_ready_o), 0);
        check("sr_valid_c1", 32'(b8.valid_o), 0);
        tick();
        check("sr_valid_c2", 32'(b8.valid_o), 1);
        check("sr_addr", 32'(b8.addr_o), 0);
        check("sr_rw", 32'(b8.rw_o), 0);
        tick();
        check("sr_valid_c3", 32'(b8.valid_o), 0);
        tick();
        tick();
        beat8(16'h0000, 1'b0, 16'h00A5);
        check("sr_m0_rvalid", 32'(b8.m0_rvalid_o), 1);
        check("sr_m0_rdata", 32'(b8.m0_rdata_o), 'h00A5);
        check("sr_m0_timeout", 32'(b8.m0_timeout_o), 0);
        check("sr_m0_ready", 32'(b8.m0_ready_o), 1);
        check("sr_m1_untouched", 32'({b8.m1_rvalid_o, b8.m1_ready_o}), 'b01);
        tick();
        check("sr_rvalid_one_cycle", 32'(b8.m0_rvalid_o), 0);

        // Timeout: m1 reads 0x0042, tail silent, response 9 cycles after valid_o
        b8.m1_addr_i = 16'h0042; b8.m1_rw_i = 1'b0; b8.m1_valid_i = 1'b1;
        tick();
        b8.m1_valid_i = 1'b0;
        wait_valid8("to_valid");
        for (int i = 0; i < 8; i++) tick();
        check("to_no_early_rvalid", 32'(b8.m1_rvalid_o), 0);
        tick();
        check("to_m1_rvalid", 32'(b8.m1_rvalid_o), 1);
        check("to_m1_timeout", 32'(b8.m1_timeout_o), 1);
        check("to_m1_rdata", 32'(b8.m1_rdata_o), 0);
        check("to_m1_ready", 32'(b8.m1_ready_o), 1);
        tick();

        // Stray beat in IDLE matching the held head address, then mismatched beats in WAIT
        beat8(16'h0042, 1'b0, 16'hDEAD);
        check("stray_idle_ignored", 32'({b8.m0_rvalid_o, b8.m1_rvalid_o}), 0);
        b8.m0_addr_i = 16'h0007; b8.m0_rw_i = 1'b0; b8.m0_valid_i = 1'b1;
        tick();
        b8.m0_valid_i = 1'b0;
        wait_valid8("mm_valid");
        beat8(16'h0008, 1'b0, 16'hBEEF);
        check("mm_wrong_addr_ignored", 32'(b8.m0_rvalid_o), 0);
        beat8(16'h0007, 1'b1, 16'hBEEF);
        check("mm_wrong_rw_ignored", 32'(b8.m0_rvalid_o), 0);
        beat8(16'h0007, 1'b0, 16'h0C0D);
        check("mm_good_rvalid", 32'(b8.m0_rvalid_o), 1);
        check("mm_good_rdata", 32'(b8.m0_rdata_o), 'h0C0D);
        check("mm_good_timeout", 32'(b8.m0_timeout_o), 0);
        tick();

        // Beat coincides with timer==TIMEOUT on the TIMEOUT=4 instance
        b4.m0_addr_i = 16'h0010; b4.m0_rw_i = 1'b0; b4.m0_valid_i = 1'b1;
        tick();
        b4.m0_valid_i = 1'b0;
        tick();
        check("co_valid", 32'(b4.valid_o), 1);
        for (int i = 0; i < 4; i++) tick();
        check("co_no_early_rvalid", 32'(b4.m0_rvalid_o), 0);
        b4.ret_addr_i = 16'h0010; b4.ret_rw_i = 1'b0; b4.ret_rdata_i = 16'h4444; b4.ret_valid_i = 1'b1;
        tick();
        b4.ret_valid_i = 1'b0;
        check("co_rvalid", 32'(b4.m0_rvalid_o), 1);
        check("co_timeout", 32'(b4.m0_timeout_o), 0);
        check("co_rdata", 32'(b4.m0_rdata_o), 'h4444);
        tick();

        // Reset mid-WAIT
        b8.m0_addr_i = 16'h0020; b8.m0_rw_i = 1'b0; b8.m0_valid_i = 1'b1;
        tick();
        b8.m0_valid_i = 1'b0;
        wait_valid8("rw_valid");
        tick();
        rst_n = 1'b0;
        #1;
        check("rw_m0_ready", 32'(b8.m0_ready_o), 1);
        check("rw_head_cleared", 32'({b8.addr_o, b8.valid_o, b8.rw_o}), 0);
        check("rw_resp_cleared", 32'({b8.m0_rvalid_o, b8.m0_rdata_o, b8.m0_timeout_o}), 0);
        tick();
        rst_n = 1'b1;
        beat8(16'h0020, 1'b0, 16'h9999);
        check("rw_late_beat_ignored", 32'({b8.m0_rvalid_o, b8.m1_rvalid_o}), 0);
        b8.m0_valid_i = 1'b1;
        tick();
        b8.m0_valid_i = 1'b0;
        wait_valid8("rw_next_valid");
        check("rw_next_addr", 32'(b8.addr_o), 'h0020);
        tick();
        beat8(16'h0020, 1'b0, 16'h7777);
        check("rw_next_rvalid", 32'(b8.m0_rvalid_o), 1);
        check("rw_next_rdata", 32'(b8.m0_rdata_o), 'h7777);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares one downstream core-bus chain (the addr/wdata/rdata/rw/valid ring that threads through io_core and the other cores) between two bus masters, e.g. the host UART bridge and an on-chip sequencer. Each master posts one transaction into a one-deep slot. A round-robin scheduler issues one transaction at a time onto the chain head. It then waits for the matching beat at the chain tail, or a timeout, and routes the response back to the issuing master.

## Interface
Parameters:
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 16, bus data width
- TIMEOUT, 64, max WAIT cycles before a transaction is abandoned (≥1)

Ports (x ∈ {0,1}):
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mx_addr_i  in  ADDR_WIDTH  master x request address
- mx_wdata_i  in  DATA_WIDTH  master x write data
- mx_rw_i  in  1  master x 1=write, 0=read
- mx_valid_i  in  1  master x request strobe, sampled only while mx_ready_o=1
- mx_ready_o  out  1  master x slot empty
- mx_rdata_o  out  DATA_WIDTH  response data, valid with mx_rvalid_o
- mx_rvalid_o  out  1  one-cycle response strobe
- mx_timeout_o  out  1  qualifies mx_rvalid_o: 1 = transaction timed out
- addr_o, wdata_o  out  ADDR_WIDTH/DATA_WIDTH  chain head request
- rw_o, valid_o  out  1  chain head rw / one-cycle request strobe
- ret_addr_i, ret_wdata_i, ret_rdata_i  in  ADDR/DATA/DATA  chain tail beat
- ret_rw_i, ret_valid_i  in  1  chain tail rw / strobe

## Operation
- Slot capture: mx_valid_i && mx_ready_o stores {addr, wdata, rw}. mx_ready_o drops the next cycle. A valid while not ready is ignored.
- FSM states:
  - IDLE: if any slot is full, grant it. If both are full, grant the master ≠ last_grant. Registered chain outputs take the slot contents, valid_o=1 for one cycle, timer←0, → WAIT.
  - WAIT: valid_o=0 and addr_o/wdata_o/rw_o hold. The timer increments each cycle, saturating.
- Accepting a return beat: a beat is accepted when ret_valid_i=1, ret_addr_i equals the issued address and ret_rw_i equals the issued rw.
  - On acceptance: mg_rdata_o←ret_rdata_i (writes pass it through unchanged), mg_rvalid_o=1, mg_timeout_o=0. The slot clears, last_grant←g, → IDLE.
  - Non-matching beats, and any ret_valid_i in IDLE, are ignored.
- Timeout: in WAIT, if timer==TIMEOUT and no beat is accepted that cycle, the granted master gets mg_rdata_o=0, mg_rvalid_o=1, mg_timeout_o=1. The slot clears, last_grant←g, → IDLE.
- A beat accepted in the same cycle as the timeout condition wins.
- Timer width is $clog2(TIMEOUT+1).
- The non-granted slot may fill at any time and is never disturbed.

Reset values (rst_n=0, asynchronous):
- State IDLE, both slots empty, mx_ready_o=1.
- All rdata/rvalid/timeout outputs and addr_o/wdata_o/rw_o/valid_o are 0.
- Timer 0, last_grant=1, so m0 wins the first tie.
- Reset mid-WAIT abandons the transaction with no response. Stale tail beats arriving later in IDLE are ignored.

## Timing
- Request strobe in cycle 0 → mx_ready_o low from cycle 1 → valid_o high in cycle 2 if IDLE was uncontended in cycle 1.
- Accepted beat in cycle k → mx_rvalid_o high in cycle k+1, mx_ready_o high in cycle k+1, state IDLE in k+1. The earliest next valid_o is k+2.
- Timeout: valid_o in cycle t, timer==TIMEOUT in cycle t+TIMEOUT, response in t+TIMEOUT+1.
- A slot freed in cycle k+1 cannot capture before the cycle k+1 edge. A master strobe coincident with its own response cycle is accepted.
- mx_rvalid_o and valid_o are exactly one cycle wide. At most one mx_rvalid_o is asserted per cycle.

## Test plan
- Single read: m0 reads addr 0x0000, tail returns rdata 0x00A5 three cycles after valid_o. Required: valid_o in cycle 2, m0_rvalid_o with rdata 0x00A5 and timeout 0, m1 untouched.
- Contention: m0 writes 0x0003←0x1234 and m1 reads 0x0001 in the same cycle, repeated for 4 rounds with an echoing tail. Required grant order m0,m1,m0,m1 and no overlapping valid_o.
- Timeout (TIMEOUT=8): m1 reads and the tail stays silent. Required: m1_rvalid_o with timeout=1 and rdata 0x0000 exactly 9 cycles after valid_o; m1_ready_o high in that same cycle.
- Stray and mismatched beats: ret_valid_i in IDLE, plus a beat with a wrong address during WAIT. Required: both ignored, and the correct beat that follows is delivered.
- Return and timeout coincide (TIMEOUT=4, beat arriving at timer==4). Required: timeout=0 with the beat data.
- Reset mid-WAIT: rst_n low for 1 cycle. Required: all outputs 0 and ready high immediately; a late tail beat produces no rvalid; the next m0 request completes normally.
